// File: rtl/bus_width_fifo.sv
// Write-wide / read-narrow FIFO: each accepted write stores RATIO lanes of OUT_W bits (lane 0 first).
// Read latency is 1 cycle (registered head), or 0 when FWFT_EN is defined (first-word fall-through).
// Backpressure: write_ready drops when fewer than RATIO words are free; rejected pushes and pops set sticky error flags.
module bus_width_fifo #(
    parameter int OUT_W = 64,
    parameter int RATIO = 2,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [OUT_W*RATIO-1:0]   write_data,
    output logic                     write_ready,
    input  logic                     read_en,
    output logic [OUT_W-1:0]         read_data,
    output logic                     read_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fifo_full,
    output logic                     fifo_half_full,
    output logic                     fifo_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Credit is based on the registered count only; a same-cycle pop never funds a push.
    assign write_ready    = (count <= CNT_W'(DEPTH - RATIO));
    assign fifo_full      = (count == CNT_W'(DEPTH));
    assign fifo_half_full = (count >= CNT_W'(DEPTH / 2));
    assign fifo_empty     = (count == '0);

    assign wr_acc = write_en && write_ready;
    assign rd_acc = read_en && !fifo_empty;

    // write_ptr stays RATIO-aligned, so a beat's lanes never straddle the wrap.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            for (int k = 0; k < RATIO; k++) begin
                mem[write_ptr + PTR_W'(k)] <= write_data[k*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                write_ptr <= write_ptr + PTR_W'(RATIO);
            end
            if (rd_acc) begin
                read_ptr <= read_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(RATIO);
                2'b01:   count <= count - CNT_W'(1);
                2'b11:   count <= count + CNT_W'(RATIO - 1);
                default: count <= count;
            endcase
            if (write_en && !write_ready) begin
                overflow <= 1'b1;
            end
            if (read_en && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FWFT_EN
    assign read_data  = mem[read_ptr];
    assign read_valid = !fifo_empty && !rst;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data  <= '1;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_acc;
            if (rd_acc) begin
                read_data <= mem[read_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_width_fifo.sv
// Scoreboard bench for bus_width_fifo (default parameters); also builds with FWFT_EN defined.
module tb_bus_width_fifo;

    localparam int OUT_W = 64;
    localparam int RATIO = 2;
    localparam int DEPTH = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   write_en = 1'b0;
    logic [OUT_W*RATIO-1:0] write_data = '0;
    logic                   write_ready;
    logic                   read_en = 1'b0;
    logic [OUT_W-1:0]       read_data;
    logic                   read_valid;
    logic [5:0]             count;
    logic                   fifo_full;
    logic                   fifo_half_full;
    logic                   fifo_empty;
    logic                   overflow;
    logic                   underflow;

    bus_width_fifo #(.OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .write_en       (write_en),
        .write_data     (write_data),
        .write_ready    (write_ready),
        .read_en        (read_en),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .count          (count),
        .fifo_full      (fifo_full),
        .fifo_half_full (fifo_half_full),
        .fifo_empty     (fifo_empty),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] sb[$];
    int          m_count = 0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        m_vld = 1'b0;
    logic [63:0] m_rd = '1;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] beat(input int n);
        logic [63:0] l0, l1;
        l0 = 64'hA0A0_0000_0000_0000 + 64'(2 * n);
        l1 = 64'hB0B0_0000_0000_0000 + 64'(2 * n + 1);
        return {l1, l0};
    endfunction

    task automatic check_outputs();
        chk_eq("count", 64'(count), 64'(m_count));
        chk_eq("empty", 64'(fifo_empty), 64'(m_count == 0));
        chk_eq("full", 64'(fifo_full), 64'(m_count == DEPTH));
        chk_eq("half", 64'(fifo_half_full), 64'(m_count >= DEPTH / 2));
        chk_eq("wready", 64'(write_ready), 64'(m_count <= DEPTH - RATIO));
        chk_eq("ovf", 64'(overflow), 64'(m_ovf));
        chk_eq("unf", 64'(underflow), 64'(m_unf));
`ifdef FWFT_EN
        chk_eq("rvalid", 64'(read_valid), 64'(m_count != 0));
        if (m_count != 0) chk_eq("rdata", read_data, sb[0]);
`else
        chk_eq("rvalid", 64'(read_valid), 64'(m_vld));
        chk_eq("rdata", read_data, m_rd);
`endif
    endtask

    // Starts and ends on a falling edge.
    task automatic step(input logic we, input logic [127:0] wd, input logic re);
        logic wa, ra;
        logic [63:0] tmp;
        check_outputs();
        wa = we && (m_count <= DEPTH - RATIO);
        ra = re && (m_count != 0);
        write_en   = we;
        write_data = wd;
        read_en    = re;
        @(posedge clk);
`ifdef FWFT_EN
        if (ra) tmp = sb.pop_front();
`else
        m_vld = ra;
        if (ra) m_rd = sb.pop_front();
`endif
        if (wa) begin
            sb.push_back(wd[63:0]);
            sb.push_back(wd[127:64]);
        end
        if (we && !wa) m_ovf = 1'b1;
        if (re && m_count == 0) m_unf = 1'b1;
        m_count = m_count + (wa ? RATIO : 0) - (ra ? 1 : 0);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    // Reset with live requests to show they are ignored.
    task automatic do_reset();
        rst        = 1'b1;
        write_en   = 1'b1;
        read_en    = 1'b1;
        write_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_vld   = 1'b0;
        m_rd    = '1;
        check_outputs();
    endtask

    task automatic writes(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b1, beat(base + i), 1'b0);
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        // 1: basic two-lane write, two reads
        do_reset();
        step(1'b1, {64'h2, 64'h1}, 1'b0);
        chk_eq("t1_cnt2", 64'(count), 64'd2);
        step(1'b0, '0, 1'b1);
        chk_eq("t1_cnt1", 64'(count), 64'd1);
`ifndef FWFT_EN
        chk_eq("t1_rd0", read_data, 64'h1);
`endif
        step(1'b0, '0, 1'b1);
        chk_eq("t1_cnt0", 64'(count), 64'd0);
`ifndef FWFT_EN
        chk_eq("t1_rd1", read_data, 64'h2);
`endif
        step(1'b0, '0, 1'b0);
        chk_eq("t1_empty", 64'(fifo_empty), 64'd1);

        // 2: fill, overflow, drain
        do_reset();
        writes(16, 0);
        chk_eq("t2_cnt", 64'(count), 64'd32);
        chk_eq("t2_full", 64'(fifo_full), 64'd1);
        chk_eq("t2_rdy", 64'(write_ready), 64'd0);
        step(1'b1, beat(99), 1'b0);
        chk_eq("t2_ovf", 64'(overflow), 64'd1);
        reads(32);
        step(1'b0, '0, 1'b0);

        // 3: underflow on empty
        do_reset();
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk_eq("t3_unf", 64'(underflow), 64'd1);
`ifndef FWFT_EN
        chk_eq("t3_rd", read_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        // 4: simultaneous push/pop, and at count 31
        do_reset();
        writes(5, 10);
        step(1'b1, beat(20), 1'b1);
        chk_eq("t4_cnt11", 64'(count), 64'd11);
        reads(11);
        do_reset();
        writes(16, 30);
        reads(1);
        chk_eq("t4_cnt31", 64'(count), 64'd31);
        step(1'b1, beat(60), 1'b1);
        chk_eq("t4_cnt30", 64'(count), 64'd30);
        chk_eq("t4_ovf", 64'(overflow), 64'd1);
        reads(30);
        step(1'b0, '0, 1'b0);

        // 5: pointer wrap
        do_reset();
        writes(12, 100);
        reads(24);
        writes(8, 200);
        reads(16);
        step(1'b0, '0, 1'b0);

        // 6: reset mid-burst, then reuse
        do_reset();
        writes(6, 300);
        chk_eq("t6_cnt12", 64'(count), 64'd12);
        do_reset();
        chk_eq("t6_cnt0", 64'(count), 64'd0);
        chk_eq("t6_empty", 64'(fifo_empty), 64'd1);
        writes(2, 400);
        reads(4);
        step(1'b0, '0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 2) != 0));
        end
        reads(DEPTH + 1);
        step(1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
